// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register in-flight write counters
// (plus one for the condition code) that drive the issue/stall decision.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET_N,
  input  logic             I_IssueValid,
  input  logic             I_Src1En,
  input  logic [IDX_W-1:0] I_Src1Idx,
  input  logic             I_Src2En,
  input  logic [IDX_W-1:0] I_Src2Idx,
  input  logic             I_DestEn,
  input  logic [IDX_W-1:0] I_DestIdx,
  input  logic             I_CCRead,
  input  logic             I_CCWrite,
  input  logic             I_GPUStall,
  input  logic             I_WBValid,
  input  logic             I_WBRegEn,
  input  logic [IDX_W-1:0] I_WBIdx,
  input  logic             I_WBCCEn,
  output logic             O_DepStall,
  output logic             O_Issue,
  output logic             O_Busy,
  output logic             O_Error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               BYP_EN  = (BYPASS != 0);

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [CNT_W-1:0]    r_cc_cnt;
  logic                r_busy;
  logic                r_error;

  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]    w_cc_nxt;
  logic [CNT_W-1:0]    w_src1_cnt;
  logic [CNT_W-1:0]    w_src2_cnt;
  logic [CNT_W-1:0]    w_dest_cnt;
  logic [NUM_REGS-1:0] w_inc_vec;
  logic [NUM_REGS-1:0] w_dec_vec;
  logic                w_wb_reg;
  logic                w_wb_cc;
  logic                w_src1_hz;
  logic                w_src2_hz;
  logic                w_cc_hz;
  logic                w_cap_hz;
  logic                w_issue;
  logic                w_underflow;
  logic                w_busy_nxt;

  // Saturating +1/-1; a simultaneous issue and retire leave the count alone.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    next_cnt = cnt;
    if (inc && !dec && cnt != CNT_MAX)   next_cnt = cnt + CNT_ONE;
    else if (dec && !inc && cnt != '0)   next_cnt = cnt - CNT_ONE;
  endfunction

  // Indices that match no entry read back as 0, so they never hazard or update.
  always_comb begin : lookup
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_src1_cnt = '0;
    w_src2_cnt = '0;
    w_dest_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (I_Src1Idx == IDX_W'(i)) w_src1_cnt = r_cnt[i];
      if (I_Src2Idx == IDX_W'(i)) w_src2_cnt = r_cnt[i];
      if (I_DestIdx == IDX_W'(i)) w_dest_cnt = r_cnt[i];
    end
  end

  assign w_wb_reg = I_WBValid & I_WBRegEn;
  assign w_wb_cc  = I_WBValid & I_WBCCEn;

  assign w_src1_hz = I_Src1En && (w_src1_cnt != '0) &&
                     !(BYP_EN && w_wb_reg && (I_WBIdx == I_Src1Idx) && (w_src1_cnt == CNT_ONE));
  assign w_src2_hz = I_Src2En && (w_src2_cnt != '0) &&
                     !(BYP_EN && w_wb_reg && (I_WBIdx == I_Src2Idx) && (w_src2_cnt == CNT_ONE));
  assign w_cc_hz   = I_CCRead && (r_cc_cnt != '0) &&
                     !(BYP_EN && w_wb_cc && (r_cc_cnt == CNT_ONE));
  // Capacity ignores a same-cycle retire to keep the full-counter path short.
  assign w_cap_hz  = (I_DestEn && (w_dest_cnt == CNT_MAX)) ||
                     (I_CCWrite && (r_cc_cnt == CNT_MAX));

  assign O_DepStall = I_IssueValid & (w_src1_hz | w_src2_hz | w_cc_hz | w_cap_hz);
  assign w_issue    = I_IssueValid & ~O_DepStall & ~I_GPUStall;
  assign O_Issue    = w_issue;

  always_comb begin : decode
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc_vec[i] = w_issue & I_DestEn & (I_DestIdx == IDX_W'(i));
      w_dec_vec[i] = w_wb_reg & (I_WBIdx == IDX_W'(i));
    end
  end

  always_comb begin : next_state
    w_underflow = w_wb_cc & ~(w_issue & I_CCWrite) & (r_cc_cnt == '0);
    w_cc_nxt    = next_cnt(r_cc_cnt, w_issue & I_CCWrite, w_wb_cc);
    w_busy_nxt  = (w_cc_nxt != '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = next_cnt(r_cnt[i], w_inc_vec[i], w_dec_vec[i]);
      w_underflow  = w_underflow | (w_dec_vec[i] & ~w_inc_vec[i] & (r_cnt[i] == '0));
      w_busy_nxt   = w_busy_nxt | (w_cnt_nxt[i] != '0);
    end
  end

  // NOTE: the counter array is flops, not RAM, so it must be cleared by reset.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_cc_cnt <= '0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_cc_cnt <= w_cc_nxt;
      r_busy   <= w_busy_nxt;
      r_error  <= r_error | w_underflow;
    end
  end

  assign O_Busy  = r_busy;
  assign O_Error = r_error;

endmodule
